// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32 integer datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  // 3-bit ALU operation codes driven by the control unit
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

endpackage

// File: rtl/register_bank.sv
// 32x32 register bank: two async read ports, one sync write port, x0 hardwired to zero.
// Latency: reads combinational; a write is visible on the read ports after the writing edge.
// Backpressure: none; a write is accepted every cycle write_rb is high.
module register_bank
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write_rb,
  input  logic [REG_IDX_W-1:0] rd_0,
  input  logic [REG_IDX_W-1:0] rs_1,
  input  logic [REG_IDX_W-1:0] rs_2,
  input  logic [XLEN-1:0]      writedata,
  output logic [XLEN-1:0]      readdata_1,
  output logic [XLEN-1:0]      readdata_2
);

  logic [XLEN-1:0] regs [NREGS];

  // Register storage: async clear beats a concurrent write; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_rb && (rd_0 != '0)) begin
      regs[rd_0] <= writedata;
    end
  end

  // Read ports: no write-through, so the old value shows until the edge; x0 forced to zero.
  always_comb begin
    readdata_1 = (rs_1 == '0) ? '0 : regs[rs_1];
    readdata_2 = (rs_2 == '0) ? '0 : regs[rs_2];
  end

endmodule

// File: rtl/datapath.sv
// RV32 integer datapath: register bank feeding a combinational ALU.
// Latency: alu_result is zero-latency from indices/control; register writes land at posedge clk.
// Backpressure: none; inputs are consumed every cycle.
module datapath
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write_rb,
  input  logic [REG_IDX_W-1:0] rd_0,
  input  logic [REG_IDX_W-1:0] rs_1,
  input  logic [REG_IDX_W-1:0] rs_2,
  input  logic [XLEN-1:0]      writedata,
  input  logic [2:0]           alu_control,
  output logic [XLEN-1:0]      alu_result
);

  logic [XLEN-1:0] readdata_1;
  logic [XLEN-1:0] readdata_2;
  alu_op_t         alu_op;

  assign alu_op = alu_op_t'(alu_control);

  register_bank REGISTER_BANK (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_rb   (write_rb),
    .rd_0       (rd_0),
    .rs_1       (rs_1),
    .rs_2       (rs_2),
    .writedata  (writedata),
    .readdata_1 (readdata_1),
    .readdata_2 (readdata_2)
  );

  // ALU: A = read port 1, B = read port 2; arithmetic wraps mod 2^32, shifts use B[4:0].
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_AND: alu_result = readdata_1 & readdata_2;
      ALU_OR:  alu_result = readdata_1 | readdata_2;
      ALU_ADD: alu_result = readdata_1 + readdata_2;
      ALU_XOR: alu_result = readdata_1 ^ readdata_2;
      ALU_SLL: alu_result = readdata_1 << readdata_2[4:0];
      ALU_SRL: alu_result = readdata_1 >> readdata_2[4:0];
      ALU_SUB: alu_result = readdata_1 - readdata_2;
      ALU_SLT: alu_result = {31'b0, $signed(readdata_1) < $signed(readdata_2)};
      default: alu_result = '0;
    endcase
  end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: expected values queued at stimulus, popped at sampling.
// Latency: n/a.
// Backpressure: n/a.
module tb_datapath;

  logic        clk;
  logic        rst_n;
  logic        write_rb;
  logic [4:0]  rd_0;
  logic [4:0]  rs_1;
  logic [4:0]  rs_2;
  logic [31:0] writedata;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q [$];

  datapath dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_rb    (write_rb),
    .rd_0        (rd_0),
    .rs_1        (rs_1),
    .rs_2        (rs_2),
    .writedata   (writedata),
    .alu_control (alu_control),
    .alu_result  (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish before limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now
  task automatic pop_chk(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: got 0x%08h want <queued value, queue empty>", tag, got);
    end else begin
      e = exp_q.pop_front();
      chk(tag, got, e);
    end
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    write_rb  = 1'b1;
    rd_0      = idx;
    writedata = data;
    @(posedge clk);
    #1;
    write_rb  = 1'b0;
  endtask

  task automatic alu_case(input string tag, input logic [2:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [31:0] exp);
    @(negedge clk);
    alu_control = op;
    rs_1 = a;
    rs_2 = b;
    push_exp(exp);
    #1;
    pop_chk(tag, alu_result);
  endtask

  initial begin
    rst_n = 1'b0; write_rb = 1'b0; rd_0 = '0; rs_1 = '0; rs_2 = '0;
    writedata = '0; alu_control = 3'b010;

    // Reset state: registers read 0 and ALU shows 0 op 0
    #3;
    push_exp(32'h0); pop_chk("reset_alu", alu_result);
    rs_1 = 5'd17; #1;
    push_exp(32'h0); pop_chk("reset_rd1", dut.REGISTER_BANK.readdata_1);
    @(negedge clk); rst_n = 1'b1;

    // Write/readback of every register, x0 must ignore its write
    for (int i = 0; i < 32; i++) begin
      rs_1 = 5'(i);
      write_reg(5'(i), 32'((i + 1) * 2));
      push_exp(i == 0 ? 32'h0 : 32'((i + 1) * 2));
      pop_chk($sformatf("wr_rb_x%0d", i), dut.REGISTER_BANK.readdata_1);
    end

    // Both ports on the same register
    rs_1 = 5'd9; rs_2 = 5'd9; #1;
    push_exp(32'd20); pop_chk("same_reg_rd2", dut.REGISTER_BANK.readdata_2);

    // ADD sweep over all nonzero register pairs
    alu_control = 3'b010;
    for (int a = 1; a < 32; a++) begin
      for (int b = 1; b < 32; b++) begin
        rs_1 = 5'(a);
        rs_2 = 5'(b);
        push_exp(32'((a + 1) * 2 + (b + 1) * 2));
        #1;
        pop_chk($sformatf("add_x%0d_x%0d", a, b), alu_result);
      end
    end

    // Mid-run reset, asserted together with a pending write
    @(negedge clk);
    write_rb = 1'b1; rd_0 = 5'd5; writedata = 32'hAAAA_5555;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      rs_1 = 5'(i);
      #1;
      push_exp(32'h0);
      pop_chk($sformatf("rst_x%0d", i), dut.REGISTER_BANK.readdata_1);
    end
    rs_1 = 5'd3; rs_2 = 5'd5; alu_control = 3'b010; #1;
    push_exp(32'h0); pop_chk("rst_alu", alu_result);
    @(negedge clk); write_rb = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    rs_1 = 5'd5; #1;
    push_exp(32'h0); pop_chk("rst_after_x5", dut.REGISTER_BANK.readdata_1);

    // Wrap and signed compare
    write_reg(5'd1, 32'hFFFF_FFFF);
    write_reg(5'd2, 32'h0000_0001);
    alu_case("wrap_add", 3'b010, 5'd1, 5'd2, 32'h0);
    alu_case("wrap_sub", 3'b110, 5'd2, 5'd1, 32'h2);
    alu_case("slt_neg",  3'b111, 5'd1, 5'd2, 32'h1);
    alu_case("slt_pos",  3'b111, 5'd2, 5'd1, 32'h0);
    alu_case("srl_1",    3'b101, 5'd1, 5'd2, 32'h7FFF_FFFF);

    // Logic ops and shift using only B[4:0]
    write_reg(5'd1, 32'hF0F0_00FF);
    write_reg(5'd2, 32'h0000_0024);
    alu_case("and", 3'b000, 5'd1, 5'd2, 32'h0000_0024);
    alu_case("or",  3'b001, 5'd1, 5'd2, 32'hF0F0_00FF);
    alu_case("xor", 3'b011, 5'd1, 5'd2, 32'hF0F0_00DB);
    alu_case("sll", 3'b100, 5'd1, 5'd2, 32'h0F00_0FF0);
    alu_case("srl", 3'b101, 5'd1, 5'd2, 32'h0F0F_000F);
    alu_case("x0_opb", 3'b001, 5'd2, 5'd0, 32'h0000_0024);

    // No write-to-read bypass, then hold with write_rb low
    write_reg(5'd7, 32'd16);
    @(negedge clk);
    write_rb = 1'b1; rd_0 = 5'd7; rs_1 = 5'd7; writedata = 32'd9;
    #1;
    push_exp(32'd16); pop_chk("nobyp_before", dut.REGISTER_BANK.readdata_1);
    @(posedge clk); #1;
    push_exp(32'd9); pop_chk("nobyp_after", dut.REGISTER_BANK.readdata_1);
    write_rb = 1'b0; writedata = 32'd5;
    @(posedge clk); #1;
    push_exp(32'd9); pop_chk("hold_x7", dut.REGISTER_BANK.readdata_1);

    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
